bp_me_mem_stream_mux: RTL and testbench
=======================================

Name: bp_me_mem_stream_mux

Overview:
- N-channel BedRock memory-stream multiplexer. Lets num_chan_p cache engines (I$ UCE/CCE instances, D$ UCE, test masters) share one mem_fwd/mem_rev port pair.
- Forward path: round-robin arbitration, with the grant locked for the duration of a multi-beat message.
- Reverse path: responses return in request order. An internal channel-ID FIFO routes each response to the channel that issued the matching request.
- Sits between the per-cache engines and the memory/L2 interface in multi-cache testbench wrappers and in the tile.

Parameters:
- num_chan_p, 2, number of requesting channels (>=1).
- header_width_p, 64, BedRock mem header width in bits.
- data_width_p, 64, stream beat data width in bits.
- max_outstanding_p, 4, maximum requests in flight (ID FIFO depth, >=1).
- lg_chan_lp, `BSG_SAFE_CLOG2(num_chan_p)`, derived ID width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset.
- fwd_header_i  in  num_chan_p*header_width_p  per-channel fwd header, channel c at slice c.
- fwd_data_i  in  num_chan_p*data_width_p  per-channel fwd beat data.
- fwd_v_i  in  num_chan_p  per-channel beat valid.
- fwd_last_i  in  num_chan_p  beat is last of message.
- fwd_ready_and_o  out  num_chan_p  per-channel ready.
- mem_fwd_header_o  out  header_width_p  muxed header.
- mem_fwd_data_o  out  data_width_p  muxed data.
- mem_fwd_v_o  out  1  muxed valid.
- mem_fwd_last_o  out  1  muxed last.
- mem_fwd_ready_and_i  in  1  downstream ready.
- mem_rev_header_i  in  header_width_p  response header.
- mem_rev_data_i  in  data_width_p  response beat.
- mem_rev_v_i  in  1  response valid.
- mem_rev_last_i  in  1  response last beat.
- mem_rev_ready_and_o  out  1  ready to memory.
- rev_header_o  out  header_width_p  broadcast response header.
- rev_data_o  out  data_width_p  broadcast response data.
- rev_v_o  out  num_chan_p  one-hot response valid.
- rev_last_o  out  1  response last.
- rev_ready_and_i  in  num_chan_p  per-channel response ready.
- credits_full_o  out  1  outstanding == max_outstanding_p.
- credits_empty_o  out  1  outstanding == 0.

Behaviour:
- Clocking and reset (already decided): one clock, clk_i. Reset reset_n_i is synchronous, active-low.
- Reset clears state: rr pointer=0, lock=0, locked_id=0, outstanding count=0, ID FIFO empty.
- Reset values of outputs: mem_fwd_v_o=0, fwd_ready_and_o=0, rev_v_o=0, mem_rev_ready_and_o=0, credits_empty_o=1, credits_full_o=0.
- Reset asserted mid-message: the partial message is abandoned and all in-flight IDs are discarded. Upstream engines are reset alongside.
- Forward arbitration, unlocked:
  - Grant goes to the first channel with fwd_v_i set, searching from rr pointer upward with wrap modulo num_chan_p.
  - The grant is combinational and zero-latency.
  - mem_fwd_v_o = granted valid & ~credits_full_o.
- Forward handshake: mem_fwd_v_o & mem_fwd_ready_and_i.
  - fwd_ready_and_o[g] = mem_fwd_ready_and_i & (lock | ~credits_full_o). All other bits are 0.
  - Output header/data/last are muxed from the grant (locked_id when locked).
- First beat of a message (unlocked handshake):
  - Push granted ID into the FIFO and increment outstanding.
  - If last=0: set lock=1, locked_id=g.
  - In all cases the rr pointer becomes (g+1) mod num_chan_p.
- While locked:
  - Only locked_id is granted.
  - credits_full_o does not block beats, since the entry was already pushed.
  - The handshake with last=1 clears lock.
- Full: no new message starts while outstanding==max_outstanding_p. The full check uses the registered count, so a same-cycle pop does not enable a push.
- Reverse routing:
  - Let h = FIFO head. rev_v_o = onehot(h) & {num_chan_p{mem_rev_v_i & ~credits_empty_o}}.
  - mem_rev_ready_and_o = ~credits_empty_o & rev_ready_and_i[h].
  - Header/data/last pass through combinationally.
  - A handshake with mem_rev_last_i=1 pops the FIFO and decrements outstanding.
- Simultaneous push and pop: outstanding unchanged, and the FIFO must stay consistent. At depth 1 this case cannot occur, because push requires not-full.
- mem_rev_v_i while empty: not accepted (ready=0). A simulation assertion flags it as a protocol error.
- num_chan_p==1: arbitration degenerates to a pass-through, but FIFO and credit tracking remain.
- Counter width: `BSG_WIDTH(max_outstanding_p)`. It must not wrap. Assertions cover overflow and underflow.

Test Plan:
- Reset, then ch0 and ch1 both present 1-beat requests, ready=1 throughout -> handshakes in order ch0 then ch1. FIFO holds [0,1]. credits_full_o=0 with max_outstanding_p=4.
- ch1 sends a 4-beat message while ch0 asserts valid from beat 2 -> all 4 ch1 beats are consecutive on mem_fwd. ch0 is granted the cycle after ch1's last beat.
- Issue 4 one-beat requests, no responses -> credits_full_o=1. A 5th request sees mem_fwd_v_o=0 and fwd_ready_and_o=0. One 2-beat response (last on beat 2) -> pop, then the 5th request is granted the next cycle.
- Requests from ch1 then ch0, two 2-beat responses -> rev_v_o=2'b10 for both beats of the first response, then 2'b01. rev_ready_and_i[1]=0 for 3 cycles stalls mem_rev_ready_and_o=0 for 3 cycles with no data loss.
- Same cycle: push a new request and pop via rev last at outstanding=2 -> outstanding stays 2. FIFO order is preserved on subsequent responses.
- reset_n_i=0 asserted during beat 2 of a locked 4-beat message -> the next cycle has lock=0, credits_empty_o=1, mem_fwd_v_o=0. After release, ch0 is granted first.

Source files
------------

// File: rtl/bp_me_mem_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_mem_stream_mux
// Purpose  : N-channel BedRock memory-stream multiplexer. Round-robin forward
//            arbitration with the grant held for a whole multi-beat message.
//            Responses come back in request order and are steered to their
//            channel through an in-order channel-ID FIFO.
// Revision : 1.0  initial release
// ============================================================================
module bp_me_mem_stream_mux #(
    parameter int num_chan_p        = 2,
    parameter int header_width_p    = 64,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,

    input  logic [num_chan_p*header_width_p-1:0] fwd_header_i,
    input  logic [num_chan_p*data_width_p-1:0]   fwd_data_i,
    input  logic [num_chan_p-1:0]                fwd_v_i,
    input  logic [num_chan_p-1:0]                fwd_last_i,
    output logic [num_chan_p-1:0]                fwd_ready_and_o,

    output logic [header_width_p-1:0]            mem_fwd_header_o,
    output logic [data_width_p-1:0]              mem_fwd_data_o,
    output logic                                 mem_fwd_v_o,
    output logic                                 mem_fwd_last_o,
    input  logic                                 mem_fwd_ready_and_i,

    input  logic [header_width_p-1:0]            mem_rev_header_i,
    input  logic [data_width_p-1:0]              mem_rev_data_i,
    input  logic                                 mem_rev_v_i,
    input  logic                                 mem_rev_last_i,
    output logic                                 mem_rev_ready_and_o,

    output logic [header_width_p-1:0]            rev_header_o,
    output logic [data_width_p-1:0]              rev_data_o,
    output logic [num_chan_p-1:0]                rev_v_o,
    output logic                                 rev_last_o,
    input  logic [num_chan_p-1:0]                rev_ready_and_i,

    output logic                                 credits_full_o,
    output logic                                 credits_empty_o
);

    localparam int lg_chan_lp   = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    localparam logic [cnt_width_lp-1:0] max_cnt_lp   = cnt_width_lp'(max_outstanding_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp  = ptr_width_lp'(max_outstanding_p - 1);
    localparam logic [lg_chan_lp-1:0]   last_chan_lp = lg_chan_lp'(num_chan_p - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [lg_chan_lp-1:0]   rr_q, rr_d;
    logic                    lock_q, lock_d;
    logic [lg_chan_lp-1:0]   locked_id_q, locked_id_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [lg_chan_lp-1:0]   fifo_q [max_outstanding_p];

    // ------------------------------------------------------------------------
    // Forward arbitration
    // ------------------------------------------------------------------------
    logic [num_chan_p-1:0] w_rr_mask;
    logic [num_chan_p-1:0] w_req_hi;
    logic [num_chan_p-1:0] w_req;
    logic [num_chan_p-1:0] w_arb_oh;
    logic [num_chan_p-1:0] w_lock_oh;
    logic [num_chan_p-1:0] w_gnt_oh;
    logic [num_chan_p-1:0] w_head_oh;
    logic [lg_chan_lp-1:0] w_gnt_id;
    logic [lg_chan_lp-1:0] w_head_id;
    logic [lg_chan_lp-1:0] w_rr_next;
    logic                  w_gnt_v;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_fwd_open;
    logic                  w_fwd_hs;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rev_open;

    // One-hot/id accumulation chains: channel c contributes at stage c+1.
    logic [lg_chan_lp-1:0]     w_id_acc  [num_chan_p+1];
    logic [header_width_p-1:0] w_hdr_acc [num_chan_p+1];
    logic [data_width_p-1:0]   w_dat_acc [num_chan_p+1];

    assign w_id_acc[0]  = '0;
    assign w_hdr_acc[0] = '0;
    assign w_dat_acc[0] = '0;

    generate
        for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
            assign w_rr_mask[c]   = (lg_chan_lp'(c) >= rr_q);
            assign w_lock_oh[c]   = (locked_id_q == lg_chan_lp'(c));
            assign w_head_oh[c]   = (w_head_id == lg_chan_lp'(c));
            assign w_id_acc[c+1]  = w_id_acc[c] | (w_gnt_oh[c] ? lg_chan_lp'(c) : '0);
            assign w_hdr_acc[c+1] = w_hdr_acc[c]
                                  | ({header_width_p{w_gnt_oh[c]}}
                                     & fwd_header_i[c*header_width_p +: header_width_p]);
            assign w_dat_acc[c+1] = w_dat_acc[c]
                                  | ({data_width_p{w_gnt_oh[c]}}
                                     & fwd_data_i[c*data_width_p +: data_width_p]);
        end
    endgenerate

    // Requests at or above the rr pointer win first; if none, wrap to the
    // lowest requester. The lowest set bit is isolated arithmetically.
    assign w_req_hi  = fwd_v_i & w_rr_mask;
    assign w_req     = (|w_req_hi) ? w_req_hi : fwd_v_i;
    assign w_arb_oh  = w_req & (~w_req + num_chan_p'(1));
    assign w_gnt_oh  = lock_q ? w_lock_oh : w_arb_oh;
    assign w_gnt_id  = w_id_acc[num_chan_p];
    assign w_gnt_v   = |(fwd_v_i & w_gnt_oh);
    assign w_rr_next = (w_gnt_id == last_chan_lp) ? '0 : w_gnt_id + lg_chan_lp'(1);

    assign w_full     = (count_q == max_cnt_lp);
    assign w_empty    = (count_q == '0);
    // A locked message already owns its FIFO entry, so full never stalls it.
    assign w_fwd_open = lock_q | ~w_full;

    assign mem_fwd_v_o      = reset_n_i & w_gnt_v & w_fwd_open;
    assign mem_fwd_header_o = w_hdr_acc[num_chan_p];
    assign mem_fwd_data_o   = w_dat_acc[num_chan_p];
    assign mem_fwd_last_o   = |(fwd_last_i & w_gnt_oh);
    assign fwd_ready_and_o  = w_gnt_oh
                            & {num_chan_p{reset_n_i & mem_fwd_ready_and_i & w_fwd_open}};

    assign w_fwd_hs = mem_fwd_v_o & mem_fwd_ready_and_i;
    assign w_push   = w_fwd_hs & ~lock_q;

    // ------------------------------------------------------------------------
    // Reverse routing
    // ------------------------------------------------------------------------
    assign w_head_id  = fifo_q[rd_ptr_q];
    assign w_rev_open = reset_n_i & ~w_empty;

    assign rev_v_o             = w_head_oh & {num_chan_p{w_rev_open & mem_rev_v_i}};
    assign mem_rev_ready_and_o = w_rev_open & (|(rev_ready_and_i & w_head_oh));
    assign rev_header_o        = mem_rev_header_i;
    assign rev_data_o          = mem_rev_data_i;
    assign rev_last_o          = mem_rev_last_i;

    assign w_pop = mem_rev_v_i & mem_rev_ready_and_o & mem_rev_last_i;

    assign credits_full_o  = w_full;
    assign credits_empty_o = w_empty;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    // Compute arbitration, lock, FIFO pointer and credit updates.
    always_comb begin
        rr_d        = rr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (w_push) begin
            rr_d     = w_rr_next;
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_width_lp'(1);
            if (!mem_fwd_last_o) begin
                lock_d      = 1'b1;
                locked_id_d = w_gnt_id;
            end
        end else if (lock_q && w_fwd_hs && mem_fwd_last_o) begin
            lock_d = 1'b0;
        end

        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_width_lp'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset abandons any partial message and in-flight IDs.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // ID FIFO storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && w_push) begin
            fifo_q[wr_ptr_q] <= w_gnt_id;
        end
    end

`ifndef SYNTHESIS
    // Protocol and credit sanity checks.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(mem_rev_v_i && w_empty))
                else $error("bp_me_mem_stream_mux: response with no request outstanding");
            assert (!(w_push && !w_pop && w_full))
                else $error("bp_me_mem_stream_mux: credit overflow");
            assert (!(w_pop && w_empty))
                else $error("bp_me_mem_stream_mux: credit underflow");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_mem_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_mem_stream_mux
// Purpose  : Directed scoreboard bench for bp_me_mem_stream_mux (2 channels,
//            4 outstanding). Expected beats are queued when stimulus is
//            issued; monitors pop and compare on every handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_me_mem_stream_mux;

    typedef struct packed {
        logic [63:0] hdr;
        logic [63:0] data;
        logic        last;
    } fbeat_t;

    typedef struct packed {
        logic [1:0]  v;
        logic [63:0] hdr;
        logic [63:0] data;
        logic        last;
    } rbeat_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] fwd_header_i = '0;
    logic [127:0] fwd_data_i = '0;
    logic [1:0]   fwd_v_i = '0;
    logic [1:0]   fwd_last_i = '0;
    logic [1:0]   fwd_ready_and_o;
    logic [63:0]  mem_fwd_header_o;
    logic [63:0]  mem_fwd_data_o;
    logic         mem_fwd_v_o;
    logic         mem_fwd_last_o;
    logic         mem_fwd_ready_and_i = 1'b1;
    logic [63:0]  mem_rev_header_i = '0;
    logic [63:0]  mem_rev_data_i = '0;
    logic         mem_rev_v_i = 1'b0;
    logic         mem_rev_last_i = 1'b0;
    logic         mem_rev_ready_and_o;
    logic [63:0]  rev_header_o;
    logic [63:0]  rev_data_o;
    logic [1:0]   rev_v_o;
    logic         rev_last_o;
    logic [1:0]   rev_ready_and_i = 2'b11;
    logic         credits_full_o;
    logic         credits_empty_o;

    int n_tests = 0;
    int n_fail  = 0;

    fbeat_t q0[$];
    fbeat_t q1[$];
    fbeat_t exp_fwd[$];
    rbeat_t rq[$];
    rbeat_t exp_rev[$];

    logic hs0 = 1'b0, hs1 = 1'b0, rhs = 1'b0;

    bp_me_mem_stream_mux #(
        .num_chan_p(2), .header_width_p(64), .data_width_p(64), .max_outstanding_p(4)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .fwd_header_i        (fwd_header_i),
        .fwd_data_i          (fwd_data_i),
        .fwd_v_i             (fwd_v_i),
        .fwd_last_i          (fwd_last_i),
        .fwd_ready_and_o     (fwd_ready_and_o),
        .mem_fwd_header_o    (mem_fwd_header_o),
        .mem_fwd_data_o      (mem_fwd_data_o),
        .mem_fwd_v_o         (mem_fwd_v_o),
        .mem_fwd_last_o      (mem_fwd_last_o),
        .mem_fwd_ready_and_i (mem_fwd_ready_and_i),
        .mem_rev_header_i    (mem_rev_header_i),
        .mem_rev_data_i      (mem_rev_data_i),
        .mem_rev_v_i         (mem_rev_v_i),
        .mem_rev_last_i      (mem_rev_last_i),
        .mem_rev_ready_and_o (mem_rev_ready_and_o),
        .rev_header_o        (rev_header_o),
        .rev_data_o          (rev_data_o),
        .rev_v_o             (rev_v_o),
        .rev_last_o          (rev_last_o),
        .rev_ready_and_i     (rev_ready_and_i),
        .credits_full_o      (credits_full_o),
        .credits_empty_o     (credits_empty_o)
    );

    always #5 clk = ~clk;

    function automatic fbeat_t mk_f(int c, int tag, int b, int n);
        fbeat_t f;
        f.hdr  = 64'h1000_0000_0000_0000 | (64'(c) << 16) | (64'(tag) << 8) | 64'(b);
        f.data = 64'hDA7A_0000_0000_0000 | (64'(c) << 24) | (64'(tag) << 4) | 64'(b);
        f.last = (b == n - 1);
        return f;
    endfunction

    task automatic send(int c, int tag, int n);
        for (int b = 0; b < n; b++) begin
            if (c == 0) q0.push_back(mk_f(c, tag, b, n));
            else        q1.push_back(mk_f(c, tag, b, n));
        end
    endtask

    task automatic exp_f(int c, int tag, int n);
        for (int b = 0; b < n; b++) exp_fwd.push_back(mk_f(c, tag, b, n));
    endtask

    // Queue a response of n beats; v is the hand-derived destination one-hot.
    task automatic rsp(logic [1:0] v, int tag, int n);
        for (int b = 0; b < n; b++) begin
            rbeat_t r;
            r.v    = v;
            r.hdr  = 64'h2000_0000_0000_0000 | (64'(tag) << 8) | 64'(b);
            r.data = 64'h5EED_0000_0000_0000 | (64'(tag) << 12) | 64'(b);
            r.last = (b == n - 1);
            rq.push_back(r);
            exp_rev.push_back(r);
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic wait_fwd(string name);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_fwd.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0 || q1.size() != 0 || exp_fwd.size() != 0) timeout(name);
    endtask

    task automatic wait_all(string name);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_fwd.size() != 0 ||
                rq.size() != 0 || exp_rev.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0 || q1.size() != 0 || exp_fwd.size() != 0 ||
            rq.size() != 0 || exp_rev.size() != 0) timeout(name);
    endtask

    // Handshakes are decided by the values stable at the negedge.
    always @(negedge clk) begin
        hs0 = reset_n & fwd_v_i[0] & fwd_ready_and_o[0];
        hs1 = reset_n & fwd_v_i[1] & fwd_ready_and_o[1];
        rhs = reset_n & mem_rev_v_i & mem_rev_ready_and_o;
    end

    // Upstream engines and memory model: present queue heads after each edge.
    always @(posedge clk) begin
        #1;
        if (hs0 && q0.size() != 0) void'(q0.pop_front());
        if (hs1 && q1.size() != 0) void'(q1.pop_front());
        if (rhs && rq.size() != 0) void'(rq.pop_front());
        fwd_v_i[0] = (q0.size() != 0);
        if (q0.size() != 0) begin
            fwd_header_i[63:0] = q0[0].hdr;
            fwd_data_i[63:0]   = q0[0].data;
            fwd_last_i[0]      = q0[0].last;
        end else begin
            fwd_last_i[0] = 1'b0;
        end
        fwd_v_i[1] = (q1.size() != 0);
        if (q1.size() != 0) begin
            fwd_header_i[127:64] = q1[0].hdr;
            fwd_data_i[127:64]   = q1[0].data;
            fwd_last_i[1]        = q1[0].last;
        end else begin
            fwd_last_i[1] = 1'b0;
        end
        mem_rev_v_i = (rq.size() != 0);
        if (rq.size() != 0) begin
            mem_rev_header_i = rq[0].hdr;
            mem_rev_data_i   = rq[0].data;
            mem_rev_last_i   = rq[0].last;
        end else begin
            mem_rev_last_i = 1'b0;
        end
    end

    // Forward monitor.
    always @(negedge clk) begin
        if (reset_n && mem_fwd_v_o && mem_fwd_ready_and_i) begin
            n_tests++;
            if (exp_fwd.size() == 0) begin
                n_fail++;
                $display("FAIL fwd_unexpected: got hdr %0h expected no beat", mem_fwd_header_o);
            end else begin
                fbeat_t e;
                fbeat_t a;
                e = exp_fwd.pop_front();
                a = '{hdr: mem_fwd_header_o, data: mem_fwd_data_o, last: mem_fwd_last_o};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL fwd_beat: got %h expected %h", a, e);
                end
            end
        end
    end

    // Reverse monitor.
    always @(negedge clk) begin
        if (reset_n && mem_rev_v_i && mem_rev_ready_and_o) begin
            n_tests++;
            if (exp_rev.size() == 0) begin
                n_fail++;
                $display("FAIL rev_unexpected: got v %b expected no beat", rev_v_o);
            end else begin
                rbeat_t e;
                rbeat_t a;
                e = exp_rev.pop_front();
                a = '{v: rev_v_o, hdr: rev_header_o, data: rev_data_o, last: rev_last_o};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL rev_beat: got %h expected %h", a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // ---- reset values ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_fwd_v", 64'(mem_fwd_v_o), 64'd0);
        check("rst_fwd_ready", 64'(fwd_ready_and_o), 64'd0);
        check("rst_rev_v", 64'(rev_v_o), 64'd0);
        check("rst_mem_rev_ready", 64'(mem_rev_ready_and_o), 64'd0);
        check("rst_empty", 64'(credits_empty_o), 64'd1);
        check("rst_full", 64'(credits_full_o), 64'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);

        // ---- 1: two single-beat requests, ch0 then ch1 ----
        send(0, 8'h11, 1); send(1, 8'h12, 1);
        exp_f(0, 8'h11, 1); exp_f(1, 8'h12, 1);
        wait_fwd("s1_fwd");
        check("s1_full", 64'(credits_full_o), 64'd0);
        check("s1_empty", 64'(credits_empty_o), 64'd0);
        rsp(2'b01, 8'h81, 1); rsp(2'b10, 8'h82, 1);
        wait_all("s1_all");
        check("s1_empty_after", 64'(credits_empty_o), 64'd1);

        // ---- 2: ch1 4-beat locked message, ch0 joins at beat 2 ----
        send(1, 8'h21, 4);
        exp_f(1, 8'h21, 4); exp_f(0, 8'h22, 1);
        @(negedge clk);
        check("s2_v_b1", 64'(mem_fwd_v_o), 64'd1);
        send(0, 8'h22, 1);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            check("s2_v", 64'(mem_fwd_v_o), 64'd1);
            check("s2_ready", 64'(fwd_ready_and_o), (i < 5) ? 64'h2 : 64'h1);
        end
        wait_fwd("s2_fwd");
        rsp(2'b10, 8'h83, 1); rsp(2'b01, 8'h84, 1);
        wait_all("s2_all");

        // ---- 3: fill credits, 5th request blocked until a 2-beat pop ----
        send(0, 8'h31, 1); send(0, 8'h32, 1);
        send(1, 8'h33, 1); send(1, 8'h34, 1);
        exp_f(1, 8'h33, 1); exp_f(0, 8'h31, 1);
        exp_f(1, 8'h34, 1); exp_f(0, 8'h32, 1);
        wait_fwd("s3_fwd");
        check("s3_full", 64'(credits_full_o), 64'd1);
        send(0, 8'h35, 1);
        exp_f(0, 8'h35, 1);
        repeat (2) begin
            @(negedge clk);
            check("s3_blk_v", 64'(mem_fwd_v_o), 64'd0);
            check("s3_blk_ready", 64'(fwd_ready_and_o), 64'd0);
        end
        rsp(2'b10, 8'h85, 2);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (!credits_full_o) break;
        end
        check("s3_unblock_cycles", 64'(k), 64'd3);
        check("s3_grant_v", 64'(mem_fwd_v_o), 64'd1);
        check("s3_grant_ready", 64'(fwd_ready_and_o), 64'h1);
        wait_fwd("s3_fwd2");
        rsp(2'b01, 8'h86, 1); rsp(2'b10, 8'h87, 1);
        rsp(2'b01, 8'h88, 1); rsp(2'b01, 8'h89, 1);
        wait_all("s3_all");
        check("s3_empty", 64'(credits_empty_o), 64'd1);

        // ---- 4: routing of 2-beat responses with a stalled ch1 ----
        send(1, 8'h41, 1); send(0, 8'h42, 1);
        exp_f(1, 8'h41, 1); exp_f(0, 8'h42, 1);
        wait_fwd("s4_fwd");
        rev_ready_and_i = 2'b01;
        rsp(2'b10, 8'h91, 2); rsp(2'b01, 8'h92, 2);
        repeat (3) begin
            @(negedge clk);
            check("s4_stall_ready", 64'(mem_rev_ready_and_o), 64'd0);
            check("s4_stall_v", 64'(rev_v_o), 64'h2);
        end
        @(posedge clk); #2 rev_ready_and_i = 2'b11;
        wait_all("s4_all");

        // ---- 5: simultaneous push and pop at outstanding 2 ----
        send(1, 8'h51, 1); send(0, 8'h52, 1);
        exp_f(1, 8'h51, 1); exp_f(0, 8'h52, 1);
        wait_fwd("s5_fwd");
        send(0, 8'h53, 1); exp_f(0, 8'h53, 1);
        rsp(2'b10, 8'hA1, 1);
        @(negedge clk);
        check("s5_both_hs", 64'({mem_fwd_v_o, mem_rev_ready_and_o, mem_rev_last_i}), 64'h7);
        wait_all("s5_sim");
        send(1, 8'h54, 1); send(0, 8'h55, 1);
        exp_f(1, 8'h54, 1); exp_f(0, 8'h55, 1);
        wait_fwd("s5_fwd2");
        check("s5_full", 64'(credits_full_o), 64'd1);
        rsp(2'b01, 8'hA2, 1); rsp(2'b01, 8'hA3, 1);
        rsp(2'b10, 8'hA4, 1); rsp(2'b01, 8'hA5, 1);
        wait_all("s5_all");
        check("s5_empty", 64'(credits_empty_o), 64'd1);

        // ---- 6: reset during beat 2 of a locked message ----
        send(1, 8'h61, 4);
        exp_fwd.push_back(mk_f(1, 8'h61, 0, 4));
        @(posedge clk);
        @(negedge clk);
        check("s6_b1_v", 64'(mem_fwd_v_o), 64'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        q1.delete();
        @(posedge clk);
        @(negedge clk);
        check("s6_rst_empty", 64'(credits_empty_o), 64'd1);
        check("s6_rst_v", 64'(mem_fwd_v_o), 64'd0);
        check("s6_rst_expq", 64'(exp_fwd.size()), 64'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        send(0, 8'h62, 1); send(1, 8'h63, 1);
        exp_f(0, 8'h62, 1); exp_f(1, 8'h63, 1);
        @(posedge clk);
        @(negedge clk);
        check("s6_first_v", 64'(mem_fwd_v_o), 64'd1);
        check("s6_first_hdr", mem_fwd_header_o, 64'h1000_0000_0000_6200);
        wait_fwd("s6_fwd");
        rsp(2'b01, 8'hB1, 1); rsp(2'b10, 8'hB2, 1);
        wait_all("s6_all");
        check("s6_empty", 64'(credits_empty_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
